// File: rtl/debug_controller_pkg.sv
// Shared types for the debug controller.
//   reg_transport : {addr, value} bundle used for register-file write ports.
//   debug_types   : command opcodes, controller states, command/response
//                   structs and the wait-counter width.
package reg_transport;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] value;
  } reg_transport_t;
endpackage

package debug_types;
  typedef enum logic [2:0] {
    STATUS = 3'd0,
    HALT   = 3'd1,
    RESUME = 3'd2,
    RDREG  = 3'd3,
    WRREG  = 3'd4,
    EXEC   = 3'd5,
    INIT   = 3'd6,
    STEP   = 3'd7
  } dbg_op_t;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    HALTED    = 3'd2,
    READ      = 3'd3,
    EXEC_WAIT = 3'd4,
    RESP      = 3'd5
  } dbg_state_t;

  typedef struct packed {
    dbg_op_t     op;
    logic [4:0]  addr;
    logic [31:0] data;
  } dbg_cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } dbg_rsp_t;

  // Wide enough for any sensible drain / exec wait.
  localparam int DBG_CNT_W = 16;
endpackage

// File: rtl/dbg_wait_counter.sv
// Down-counter shared by the DRAIN and EXEC_WAIT states.
//   iClk, nRst : clock, async active-low reset
//   i_start    : reload the count with i_load (the wait length in cycles)
//   i_load     : wait length, must be >= 1 when used
//   o_done     : high in the last cycle of the wait (count reached 1)
// The count saturates at 0 so an idle counter never wraps.
module dbg_wait_counter #(
  parameter int W = 16
) (
  input  logic         iClk,
  input  logic         nRst,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)                r_cnt <= '0;
    else if (i_start)         r_cnt <= i_load;
    else if (r_cnt != '0)     r_cnt <= r_cnt - W'(1);
  end

  assign o_done = (r_cnt <= W'(1));
endmodule

// File: rtl/debug_controller.sv
// Host-side master of the processor debug port.
// Takes commands over a valid/ready channel, drives halt / exec / init /
// register-write strobes into the core, reads registers through the debug
// read port and returns exactly one response per command.
//   iClk, nRst        : clock, async active-low reset
//   iCmd_*            : command channel {op, addr, data}
//   oRsp_*, iRsp_ready: response channel {data, err}
//   oDBG_*            : halt level, exec/init/regWrite strobes, ins, rd
//   oRs_addr/iRs_value: debug register read port
// Build option: define DBG_STEP_EN to enable the single-step op (STEP);
// without it STEP is answered with an error and halt is never released.
module debug_controller
  import debug_types::*;
  import reg_transport::*;
#(
  parameter int DRAIN_CYCLES = 5,
  parameter int EXEC_CYCLES  = 5
) (
  input  logic           iClk,
  input  logic           nRst,
  input  logic           iCmd_valid,
  output logic           oCmd_ready,
  input  logic [2:0]     iCmd_op,
  input  logic [4:0]     iCmd_addr,
  input  logic [31:0]    iCmd_data,
  output logic           oRsp_valid,
  input  logic           iRsp_ready,
  output logic [31:0]    oRsp_data,
  output logic           oRsp_err,
  output logic           oDBG_halt,
  output logic           oDBG_exec,
  output logic           oDBG_req_init,
  output logic           oDBG_regWrite,
  output logic [31:0]    oDBG_ins,
  output reg_transport_t oDBG_rd,
  output logic [4:0]     oRs_addr,
  input  logic [31:0]    iRs_value
);
  // EXEC waits one extra cycle for the strobe itself; STEP likewise spends
  // its first cycle with halt released before draining.
  localparam logic [DBG_CNT_W-1:0] L_DRAIN = DBG_CNT_W'(DRAIN_CYCLES);
  localparam logic [DBG_CNT_W-1:0] L_EXEC  = DBG_CNT_W'(EXEC_CYCLES + 1);
`ifdef DBG_STEP_EN
  localparam logic [DBG_CNT_W-1:0] L_STEP  = DBG_CNT_W'(DRAIN_CYCLES + 1);
`endif

  dbg_state_t     r_state;
  dbg_op_t        r_op;
  dbg_rsp_t       r_rsp;
  reg_transport_t r_rd;
  logic           r_halted;   // state to return to after RESP
  logic           r_halt;
  logic           r_exec;
  logic           r_init;
  logic           r_regwr;
  logic [31:0]    r_ins;
  logic [4:0]     r_rs_addr;

  dbg_cmd_t             w_cmd;
  logic                 w_cmd_ready;
  logic                 w_start;
  logic [DBG_CNT_W-1:0] w_load;
  logic                 w_done;

  assign w_cmd = '{op: dbg_op_t'(iCmd_op), addr: iCmd_addr, data: iCmd_data};
  assign w_cmd_ready = (r_state == RUN) || (r_state == HALTED);

  // Counter is loaded on the accepting edge so the first wait cycle is cycle 1.
  always_comb begin
    w_start = 1'b0;
    w_load  = L_DRAIN;
    if (iCmd_valid && w_cmd_ready) begin
      case (w_cmd.op)
        HALT: w_start = !r_halted;
        EXEC: begin
          w_start = r_halted;
          w_load  = L_EXEC;
        end
`ifdef DBG_STEP_EN
        STEP: begin
          w_start = r_halted;
          w_load  = L_STEP;
        end
`endif
        default: w_start = 1'b0;
      endcase
    end
  end

  dbg_wait_counter #(.W(DBG_CNT_W)) u_wait (
    .iClk    (iClk),
    .nRst    (nRst),
    .i_start (w_start),
    .i_load  (w_load),
    .o_done  (w_done)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= RUN;
      r_op      <= STATUS;
      r_rsp     <= '0;
      r_rd      <= '0;
      r_halted  <= 1'b0;
      r_halt    <= 1'b0;
      r_exec    <= 1'b0;
      r_init    <= 1'b0;
      r_regwr   <= 1'b0;
      r_ins     <= '0;
      r_rs_addr <= '0;
    end else begin
      // strobes and their payloads live for exactly one cycle
      r_exec  <= 1'b0;
      r_init  <= 1'b0;
      r_regwr <= 1'b0;
      r_ins   <= '0;
      r_rd    <= '0;
      case (r_state)
        RUN, HALTED: begin
          if (iCmd_valid) begin
            r_op    <= w_cmd.op;
            r_rsp   <= '0;
            r_state <= RESP;
            case (w_cmd.op)
              STATUS: r_rsp.data <= {31'b0, r_halted};
              HALT: begin
                r_halt   <= 1'b1;
                r_halted <= 1'b1;
                if (!r_halted && DRAIN_CYCLES != 0) r_state <= DRAIN;
              end
              RESUME: begin
                r_halt   <= 1'b0;
                r_halted <= 1'b0;
              end
              RDREG: begin
                if (r_halted) begin
                  r_rs_addr <= w_cmd.addr;
                  r_state   <= READ;
                end else r_rsp.err <= 1'b1;
              end
              WRREG: begin
                // x0 is forwarded as-is; the register file drops it
                if (r_halted) begin
                  r_regwr <= 1'b1;
                  r_rd    <= '{addr: w_cmd.addr, value: w_cmd.data};
                  r_state <= READ;
                end else r_rsp.err <= 1'b1;
              end
              EXEC: begin
                if (r_halted) begin
                  r_exec  <= 1'b1;
                  r_ins   <= w_cmd.data;
                  r_state <= EXEC_WAIT;
                end else r_rsp.err <= 1'b1;
              end
              INIT: r_init <= 1'b1;
`ifdef DBG_STEP_EN
              STEP: begin
                // release halt for one cycle; DRAIN re-asserts it
                if (r_halted) begin
                  r_halt  <= 1'b0;
                  r_state <= DRAIN;
                end else r_rsp.err <= 1'b1;
              end
`endif
              default: r_rsp.err <= 1'b1;
            endcase
          end
        end
        // One-cycle access slot: read data is captured here, a write has
        // already been strobed.
        READ: begin
          if (r_op == RDREG) r_rsp.data <= iRs_value;
          r_state <= RESP;
        end
        DRAIN: begin
          r_halt <= 1'b1;
          if (w_done) r_state <= RESP;
        end
        EXEC_WAIT: begin
          if (w_done) r_state <= RESP;
        end
        RESP: begin
          if (iRsp_ready) r_state <= r_halted ? HALTED : RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign oCmd_ready    = w_cmd_ready;
  assign oRsp_valid    = (r_state == RESP);
  assign oRsp_data     = r_rsp.data;
  assign oRsp_err      = r_rsp.err;
  assign oDBG_halt     = r_halt;
  assign oDBG_exec     = r_exec;
  assign oDBG_req_init = r_init;
  assign oDBG_regWrite = r_regwr;
  assign oDBG_ins      = r_ins;
  assign oDBG_rd       = r_rd;
  assign oRs_addr      = r_rs_addr;
endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Host-side master of the processor debug port.
- Accepts debug commands over a valid/ready command channel and returns one response per command over a valid/ready response channel.
- Generates the halt, exec, instruction-inject, register-write and init-request signals consumed by the processor top, and reads back registers through the debug read port.
- Sits between an external debug transport (UART/JTAG bridge) and the processor.

Parameters:
- DRAIN_CYCLES, 5, cycles to hold halt before reporting halted (pipeline drain).
- EXEC_CYCLES, 5, cycles to wait after an injected instruction before responding.

Ports:
- iClk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- iCmd_valid  in  1  command valid
- oCmd_ready  out  1  command accept
- iCmd_op  in  3  opcode (dbg_op_t)
- iCmd_addr  in  5  register index
- iCmd_data  in  32  write value / instruction word
- oRsp_valid  out  1  response valid
- iRsp_ready  in  1  response accept
- oRsp_data  out  32  read data / status
- oRsp_err  out  1  command rejected
- oDBG_halt  out  1  pipeline halt
- oDBG_exec  out  1  inject-instruction strobe
- oDBG_req_init  out  1  init request pulse
- oDBG_regWrite  out  1  debug register write strobe
- oDBG_ins  out  32  injected instruction
- oDBG_rd  out  37  reg_transport_t write target {addr, value}
- oRs_addr  out  5  debug read address
- iRs_value  in  32  debug read data

Behaviour:
- Interface decision: one clock, iClk; reset nRst is asynchronous, active-low.
- Reset values: all outputs 0 except oCmd_ready=1; state RUN.
- States: RUN, DRAIN, HALTED, READ, EXEC_WAIT, RESP.
- oCmd_ready=1 only in RUN or HALTED. A command is accepted on iCmd_valid&oCmd_ready; call that cycle 0.
- A halted flag register records the return state after RESP.
- STATUS: response at cycle 1, oRsp_data={31'b0, halted}.
- HALT from RUN: oDBG_halt=1 from cycle 1, DRAIN counts DRAIN_CYCLES, response at cycle 1+DRAIN_CYCLES.
- HALT from HALTED: response at cycle 1, no drain.
- RESUME: oDBG_halt=0 from cycle 1, response at cycle 1; ok in either state.
- RDREG, halted only: oRs_addr=iCmd_addr at cycle 1; iRs_value is registered at the end of cycle 1; oRsp_data valid at cycle 2.
- WRREG, halted only: oDBG_regWrite=1 for exactly cycle 1, with oDBG_rd={addr,data}; response at cycle 2. Writes to x0 are forwarded unchanged; the register file discards them.
- EXEC, halted only: oDBG_exec=1 and oDBG_ins=data for exactly cycle 1; EXEC_WAIT for EXEC_CYCLES; response at cycle 2+EXEC_CYCLES.
- INIT: oDBG_req_init=1 for cycle 1; response at cycle 1; halt state unchanged.
- RDREG, WRREG or EXEC while running: no DBG strobe, response at cycle 1 with oRsp_err=1, data 0.
- Undefined or disabled op: oRsp_err=1.
- RESP: oRsp_valid is held, with stable data and err, until iRsp_ready; then return to HALTED or RUN.
- oDBG_halt stays 1 through DRAIN, HALTED, READ, EXEC_WAIT and RESP-while-halted.
- Strobes are single-cycle and never overlap.
- Reset mid-operation: all strobes drop at once, halt deasserts, any pending response is lost.
- Counters saturate at their terminal count and reload on entry. When a parameter is 0, the wait state is skipped.

Optional Feature:
- Macro: DBG_STEP_EN.
- Enabled: op STEP (3'd7) is legal only when halted. oDBG_halt=0 for exactly cycle 1, then 1 again, then DRAIN_CYCLES of drain; response at cycle 2+DRAIN_CYCLES.
- STEP while running returns err.
- Disabled: op 7 returns oRsp_err=1 at cycle 1 and oDBG_halt is never released.

Decomposition:
- Package debug_types:
  - dbg_op_t enum: STATUS=0, HALT=1, RESUME=2, RDREG=3, WRREG=4, EXEC=5, INIT=6, STEP=7.
  - dbg_state_t enum.
  - dbg_cmd_t struct {op, addr, data}.
  - dbg_rsp_t struct {data, err}.
- reg_transport_t is reused from reg_transport.
- One sub-module: dbg_wait_counter (load value, start, done), shared by DRAIN and EXEC_WAIT.

Test Plan:
- Reset, then STATUS -> rsp at cycle 1, data=0, err=0; oCmd_ready=1.
- HALT -> oDBG_halt=1 at cycle 1, rsp at cycle 6 (DRAIN=5); STATUS -> data=1.
- Halted, WRREG addr=5 data=32'hDEADBEEF -> one-cycle oDBG_regWrite, oDBG_rd={5,DEADBEEF}; RDREG 5 with iRs_value modelled -> rsp data=32'hDEADBEEF at cycle 2.
- Halted, EXEC data=32'h00100093 -> oDBG_exec and oDBG_ins for one cycle, rsp at cycle 7; RESUME -> halt=0 at cycle 1.
- Running, RDREG 3 -> err=1 at cycle 1, no oRs_addr activity; hold iRsp_ready=0 for 4 cycles -> rsp stable, oCmd_ready=0.
- nRst asserted during DRAIN -> immediate all-zero outputs; next HALT takes the full DRAIN again. With DBG_STEP_EN, STEP while halted -> halt low for exactly 1 cycle.
